// File: rtl/time_of_day_counter.sv
// time_of_day_counter: free-running {hour, minute} keeper.
// A prescaler divides clk down to minute ticks, and the minute and hour fields
// count on those ticks. A new time can be loaded over a valid/ready handshake.
// Single-cycle minute/hour pulses are registered so they line up with the new
// current_time value.
// Optional build macro: TIME_SET_CHECK_EN. When it is defined, an out-of-range
// set request is rejected and set_err pulses. When it is not defined, each
// out-of-range field loads as 0 and set_err stays 0.
module time_of_day_counter #(
  parameter int DIV      = 60,
  parameter int MIN_MOD  = 10,
  parameter int HOUR_MOD = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_time,
  output logic       set_ready,
  output logic [7:0] current_time,
  output logic       minute_pulse,
  output logic       hour_pulse,
  output logic       set_err
);

  localparam int              PS_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(DIV - 1);
  localparam logic [3:0]      MIN_LAST  = 4'(MIN_MOD - 1);
  localparam logic [3:0]      HOUR_LAST = 4'(HOUR_MOD - 1);

  typedef enum logic [1:0] {STOP, RUN, LOAD} state_t;

  state_t          state, state_nxt;
  logic [PS_W-1:0] prescaler;
  logic [3:0]      minute, hour;
  logic            set_accept;
  logic            tick;

`ifdef TIME_SET_CHECK_EN
  // True when both packed fields lie inside their moduli.
  function automatic logic time_in_range(input logic [7:0] t);
    return ({1'b0, t[7:4]} < 5'(HOUR_MOD)) && ({1'b0, t[3:0]} < 5'(MIN_MOD));
  endfunction
`else
  // Forces each out-of-range field to 0 and leaves the other field untouched.
  function automatic logic [7:0] clamp_time(input logic [7:0] t);
    logic [3:0] h, m;
    h = ({1'b0, t[7:4]} < 5'(HOUR_MOD)) ? t[7:4] : 4'd0;
    m = ({1'b0, t[3:0]} < 5'(MIN_MOD))  ? t[3:0] : 4'd0;
    return {h, m};
  endfunction
`endif

  assign set_ready    = (state != LOAD);
  assign set_accept   = set_valid && set_ready;
  assign tick         = (state == RUN) && (prescaler == PS_LAST);
  assign current_time = {hour, minute};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= STOP;
    else     state <= state_nxt;
  end

  // Next-state logic. An accepted set always goes to LOAD, which lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (set_accept) state_nxt = LOAD;
               else if (run)   state_nxt = RUN;
      RUN:     if (set_accept) state_nxt = LOAD;
               else if (!run)  state_nxt = STOP;
      LOAD:    state_nxt = run ? RUN : STOP;
      default: state_nxt = STOP;
    endcase
  end

  // Prescaler, time fields and pulses. A set takes priority over a tick on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      minute       <= 4'd0;
      hour         <= 4'd0;
      minute_pulse <= 1'b0;
      hour_pulse   <= 1'b0;
    end else begin
      minute_pulse <= 1'b0;
      hour_pulse   <= 1'b0;
      if (set_accept) begin
`ifdef TIME_SET_CHECK_EN
        if (time_in_range(set_time)) begin
          hour      <= set_time[7:4];
          minute    <= set_time[3:0];
          prescaler <= '0;
        end
`else
        {hour, minute} <= clamp_time(set_time);
        prescaler      <= '0;
`endif
      end else if (state == RUN) begin
        if (tick) begin
          prescaler    <= '0;
          minute_pulse <= 1'b1;
          if (minute == MIN_LAST) begin
            minute     <= 4'd0;
            hour_pulse <= 1'b1;
            hour       <= (hour == HOUR_LAST) ? 4'd0 : hour + 4'd1;
          end else begin
            minute <= minute + 4'd1;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

`ifdef TIME_SET_CHECK_EN
  // One-cycle error pulse for each rejected set request.
  always_ff @(posedge clk) begin
    if (rst) set_err <= 1'b0;
    else     set_err <= set_accept && !time_in_range(set_time);
  end
`else
  assign set_err = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Testbench for time_of_day_counter with DIV=4, MIN_MOD=10 and HOUR_MOD=12.
// A behavioural model predicts every clock edge. The prediction is queued when
// the stimulus is driven, then popped and compared once the edge has happened.
module tb_time_of_day_counter;

  localparam int DIV      = 4;
  localparam int MIN_MOD  = 10;
  localparam int HOUR_MOD = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_time = 8'h00;
  logic       set_ready;
  logic [7:0] current_time;
  logic       minute_pulse;
  logic       hour_pulse;
  logic       set_err;

  time_of_day_counter #(.DIV(DIV), .MIN_MOD(MIN_MOD), .HOUR_MOD(HOUR_MOD)) dut (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_time(set_time),
    .set_ready(set_ready), .current_time(current_time), .minute_pulse(minute_pulse),
    .hour_pulse(hour_pulse), .set_err(set_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] t;
    logic       mp;
    logic       hp;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state. Encoding: 0 = stopped, 1 = counting, 2 = loading.
  int m_state = 0;
  int m_ps    = 0;
  int m_hour  = 0;
  int m_min   = 0;

  // Drive one cycle of stimulus, predict the result of the edge, and wait until just after it.
  task automatic apply(input bit r, input bit run_i, input bit sv, input logic [7:0] st);
    int hh, mm;
    bit mp, hp, err, acc;
    mp = 0; hp = 0; err = 0;
    if (r) begin
      m_state = 0; m_ps = 0; m_hour = 0; m_min = 0;
    end else begin
      acc = sv && (m_state != 2);
      if (acc) begin
        hh = int'(st[7:4]);
        mm = int'(st[3:0]);
`ifdef TIME_SET_CHECK_EN
        if (hh < HOUR_MOD && mm < MIN_MOD) begin
          m_hour = hh; m_min = mm; m_ps = 0;
        end else begin
          err = 1;
        end
`else
        if (hh >= HOUR_MOD) hh = 0;
        if (mm >= MIN_MOD)  mm = 0;
        m_hour = hh; m_min = mm; m_ps = 0;
`endif
      end else if (m_state == 1) begin
        if (m_ps == DIV - 1) begin
          m_ps = 0;
          mp = 1;
          m_min = m_min + 1;
          if (m_min == MIN_MOD) begin
            m_min = 0;
            hp = 1;
            m_hour = (m_hour + 1) % HOUR_MOD;
          end
        end else begin
          m_ps = m_ps + 1;
        end
      end
      m_state = acc ? 2 : (run_i ? 1 : 0);
    end
    sb.push_back('{t: 8'((m_hour << 4) | m_min), mp: mp, hp: hp, err: err,
                   rdy: (m_state != 2)});
    rst = r; run = run_i; set_valid = sv; set_time = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 1'b1, 8'h57);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL reset[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_count();
    for (int i = 0; i < 18; i++) begin
      apply(i == 0, 1'b1, 1'b0, 8'h00);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL count[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
    n_cmp++;
    if (current_time !== 8'h04) begin
      n_bad++;
      $display("FAIL count_final: got t=%h, want t=04", current_time);
    end
  endtask

  task automatic test_wrap(input string name, input logic [7:0] start, input logic [7:0] after);
    for (int i = 0; i < 9; i++) begin
      apply(i == 0, 1'b1, i == 1, start);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL %s[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 name, i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
      // The load happens at edge 1 and LOAD->RUN at edge 2, so the first tick lands on edge 6.
      if (i == 6) begin
        n_cmp++;
        if (current_time !== after || minute_pulse !== 1'b1 || hour_pulse !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_tick: got t=%h mp=%b hp=%b, want t=%h mp=1 hp=1",
                   name, current_time, minute_pulse, hour_pulse, after);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st;
    for (int i = 0; i < 14; i++) begin
      st = (i == 5) ? 8'h25 : (i == 6) ? 8'h37 : 8'h41;
      apply(i == 0, 1'b1, (i >= 5 && i <= 7), st);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 32; i++) begin
      apply(i == 0, !(i >= 7 && i <= 16), 1'b0, 8'h00);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL hold[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_run_drop_on_tick();
    for (int i = 0; i < 10; i++) begin
      apply(i == 0, (i >= 1 && i <= 4), 1'b0, 8'h00);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL rundrop[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_set_range();
    logic [7:0] st;
    for (int i = 0; i < 20; i++) begin
      st = (i == 4) ? 8'hC3 : (i == 9) ? 8'h5C : (i == 13) ? 8'hFF : 8'h00;
      apply(i == 0, 1'b1, (i == 4 || i == 9 || i == 13), st);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL range[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) begin
      apply(i == 0 || i == 2 || i == 8, 1'b1, i == 1, 8'h57);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL rstmid[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  task automatic test_random();
    bit         r, rn, sv;
    logic [7:0] st;
    for (int i = 0; i < 600; i++) begin
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      rn = ($urandom_range(0, 7) != 0);
      sv = ($urandom_range(0, 9) == 0);
      st = 8'($urandom);
      apply(r, rn, sv, st);
      e = sb.pop_front(); n_cmp++;
      if (current_time !== e.t || minute_pulse !== e.mp || hour_pulse !== e.hp ||
          set_err !== e.err || set_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL random[%0d]: got t=%h mp=%b hp=%b err=%b rdy=%b, want t=%h mp=%b hp=%b err=%b rdy=%b",
                 i, current_time, minute_pulse, hour_pulse, set_err, set_ready, e.t, e.mp, e.hp, e.err, e.rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap("hourwrap", 8'h09, 8'h10);
    test_wrap("daywrap", 8'hB9, 8'h00);
    test_back_to_back();
    test_hold();
    test_run_drop_on_tick();
    test_set_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
